// File: rtl/minigame_core.sv
// Wake-up minigame engine: shows a pseudo-random 4-digit code and waits for the player to key it
// in digit by digit, with a per-digit timeout and a saturating failure counter.
module minigame_core #(
  parameter int unsigned TIMEOUT_SEC = 10,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic       MCLK,
  input  logic       RESET,
  input  logic       minigame_enable,
  input  logic       tick_1hz,
  input  logic       key_valid,
  input  logic [3:0] key_value,
  output logic       minigame_done,
  output logic       active,
  output logic [3:0] tgt_d3,
  output logic [3:0] tgt_d2,
  output logic [3:0] tgt_d1,
  output logic [3:0] tgt_d0,
  output logic [2:0] progress,
  output logic [3:0] time_left,
  output logic [3:0] fail_cnt
);

  localparam logic [3:0] TimeoutLd = 4'(TIMEOUT_SEC);

  typedef enum logic [2:0] {StIdle, StGen, StWaitKey, StDone, StHold} state_e;

  state_e      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic        done_q, done_d;
  logic        active_q, active_d;
  logic [3:0]  d3_q, d3_d, d2_q, d2_d, d1_q, d1_d, d0_q, d0_d;
  logic [2:0]  progress_q, progress_d;
  logic [3:0]  time_left_q, time_left_d;
  logic [3:0]  fail_q, fail_d;
  logic [3:0]  expected;
  logic [3:0]  fail_inc;

  // Fold nibbles 10..15 onto 4..9 so every target digit is enterable.
  function automatic logic [3:0] digit_map(input logic [3:0] n);
    return (n <= 4'd9) ? n : n - 4'd6;
  endfunction

  always_comb begin
    unique case (progress_q)
      3'd0:    expected = d3_q;
      3'd1:    expected = d2_q;
      3'd2:    expected = d1_q;
      default: expected = d0_q;
    endcase
  end

  assign fail_inc = (fail_q == 4'd15) ? 4'd15 : fail_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    done_d      = done_q;
    active_d    = active_q;
    d3_d        = d3_q;
    d2_d        = d2_q;
    d1_d        = d1_q;
    d0_d        = d0_q;
    progress_d  = progress_q;
    time_left_d = time_left_q;
    fail_d      = fail_q;
    // Taps 16,14,13,11 on a right-shifting register (bit 0 is stage 16).
    lfsr_d      = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

    unique case (state_q)
      StIdle: begin
        active_d = 1'b0;
        if (minigame_enable) begin
          fail_d  = 4'd0;
          state_d = StGen;
        end
      end
      StGen: begin
        d3_d        = digit_map(lfsr_q[15:12]);
        d2_d        = digit_map(lfsr_q[11:8]);
        d1_d        = digit_map(lfsr_q[7:4]);
        d0_d        = digit_map(lfsr_q[3:0]);
        progress_d  = 3'd0;
        time_left_d = TimeoutLd;
        active_d    = 1'b1;
        state_d     = StWaitKey;
      end
      StWaitKey: begin
        if (!minigame_enable) begin
          active_d = 1'b0;
          state_d  = StIdle;
        end else if (key_valid) begin
          if (key_value == expected) begin
            progress_d  = progress_q + 3'd1;
            time_left_d = TimeoutLd;
            if (progress_q == 3'd3) state_d = StDone;
          end else begin
            fail_d  = fail_inc;
            state_d = StGen;
          end
        end else if (tick_1hz) begin
          time_left_d = time_left_q - 4'd1;
          if (time_left_q == 4'd1) begin
            fail_d  = fail_inc;
            state_d = StGen;
          end
        end
      end
      StDone: begin
        done_d   = 1'b1;
        active_d = 1'b0;
        state_d  = StHold;
      end
      StHold: begin
        done_d = 1'b0;
        if (!minigame_enable) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= StIdle;
      lfsr_q      <= LFSR_SEED;
      done_q      <= 1'b0;
      active_q    <= 1'b0;
      d3_q        <= 4'd0;
      d2_q        <= 4'd0;
      d1_q        <= 4'd0;
      d0_q        <= 4'd0;
      progress_q  <= 3'd0;
      time_left_q <= 4'd0;
      fail_q      <= 4'd0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      done_q      <= done_d;
      active_q    <= active_d;
      d3_q        <= d3_d;
      d2_q        <= d2_d;
      d1_q        <= d1_d;
      d0_q        <= d0_d;
      progress_q  <= progress_d;
      time_left_q <= time_left_d;
      fail_q      <= fail_d;
    end
  end

  assign minigame_done = done_q;
  assign active        = active_q;
  assign tgt_d3        = d3_q;
  assign tgt_d2        = d2_q;
  assign tgt_d1        = d1_q;
  assign tgt_d0        = d0_q;
  assign progress      = progress_q;
  assign time_left     = time_left_q;
  assign fail_cnt      = fail_q;

endmodule

// File: tb/tb_minigame_core.sv
// Bench for minigame_core: fixed vector table, directed corner sequences and random play checked
// against a behavioural model of the game.
module tb_minigame_core;

  localparam int T = 3;

  logic       MCLK = 1'b0;
  logic       RESET = 1'b1;
  logic       minigame_enable = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_value = 4'd0;
  logic       minigame_done, active;
  logic [3:0] tgt_d3, tgt_d2, tgt_d1, tgt_d0;
  logic [2:0] progress;
  logic [3:0] time_left, fail_cnt;

  int total = 0;
  int bad = 0;

  minigame_core #(.TIMEOUT_SEC(T), .LFSR_SEED(16'hACE1)) dut (
    .MCLK(MCLK), .RESET(RESET), .minigame_enable(minigame_enable), .tick_1hz(tick_1hz),
    .key_valid(key_valid), .key_value(key_value), .minigame_done(minigame_done),
    .active(active), .tgt_d3(tgt_d3), .tgt_d2(tgt_d2), .tgt_d1(tgt_d1), .tgt_d0(tgt_d0),
    .progress(progress), .time_left(time_left), .fail_cnt(fail_cnt)
  );

  always #5 MCLK = ~MCLK;

  // Reference model. Phases: 0 idle, 1 generate, 2 wait key, 3 done, 4 hold.
  localparam int PIdle = 0, PGen = 1, PWait = 2, PDone = 3, PHold = 4;
  int unsigned m_lfsr = 16'hACE1;
  int m_ph = PIdle;
  int m_tgt[4] = '{0, 0, 0, 0};  // m_tgt[0] is entered first
  int m_prog = 0, m_tl = 0, m_fail = 0, m_done = 0, m_act = 0;

  always @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      m_lfsr = 16'hACE1; m_ph = PIdle; m_prog = 0; m_tl = 0; m_fail = 0; m_done = 0; m_act = 0;
      for (int i = 0; i < 4; i++) m_tgt[i] = 0;
    end else begin
      case (m_ph)
        PIdle: if (minigame_enable) begin m_fail = 0; m_ph = PGen; end
        PGen: begin
          for (int i = 0; i < 4; i++) begin
            int nib;
            nib = int'((m_lfsr >> (12 - 4 * i)) & 15);
            m_tgt[i] = (nib > 9) ? nib - 6 : nib;
          end
          m_prog = 0; m_tl = T; m_act = 1; m_ph = PWait;
        end
        PWait: begin
          if (!minigame_enable) begin
            m_act = 0; m_ph = PIdle;
          end else if (key_valid) begin
            if (int'(key_value) == m_tgt[m_prog]) begin
              m_prog++; m_tl = T;
              if (m_prog == 4) m_ph = PDone;
            end else begin
              m_fail = (m_fail < 15) ? m_fail + 1 : 15; m_ph = PGen;
            end
          end else if (tick_1hz) begin
            m_tl--;
            if (m_tl == 0) begin m_fail = (m_fail < 15) ? m_fail + 1 : 15; m_ph = PGen; end
          end
        end
        PDone: begin m_done = 1; m_act = 0; m_ph = PHold; end
        default: begin m_done = 0; if (!minigame_enable) m_ph = PIdle; end
      endcase
      begin
        int unsigned b;
        b = (m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1;
        m_lfsr = (m_lfsr >> 1) | (b << 15);
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("done", int'(minigame_done), m_done);
    chk("active", int'(active), m_act);
    chk("tgt_d3", int'(tgt_d3), m_tgt[0]);
    chk("tgt_d2", int'(tgt_d2), m_tgt[1]);
    chk("tgt_d1", int'(tgt_d1), m_tgt[2]);
    chk("tgt_d0", int'(tgt_d0), m_tgt[3]);
    chk("progress", int'(progress), m_prog);
    chk("time_left", int'(time_left), m_tl);
    chk("fail_cnt", int'(fail_cnt), m_fail);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_done"}, int'(minigame_done), 0);
    chk({tag, "_active"}, int'(active), 0);
    chk({tag, "_tgt"}, int'({tgt_d3, tgt_d2, tgt_d1, tgt_d0}), 0);
    chk({tag, "_progress"}, int'(progress), 0);
    chk({tag, "_time_left"}, int'(time_left), 0);
    chk({tag, "_fail"}, int'(fail_cnt), 0);
  endtask

  task automatic cyc(input bit e, input bit t, input bit k, input logic [3:0] v);
    minigame_enable = e; tick_1hz = t; key_valid = k; key_value = v;
    @(posedge MCLK);
    @(negedge MCLK);
    tick_1hz = 1'b0; key_valid = 1'b0;
    check_model();
  endtask

  function automatic logic [3:0] good_key();
    return 4'(m_tgt[(m_prog < 4) ? m_prog : 0]);
  endfunction

  task automatic start_game();
    int n = 0;
    while (!active && n < 10) begin cyc(1'b1, 1'b0, 1'b0, 4'd0); n++; end
    chk("active_up", int'(active), 1);
  endtask

  typedef struct {
    bit en, tick, kv, good;
    int prog, tl, fail;
    bit act, done;
  } vec_t;

  function automatic vec_t mk(bit en, bit tick, bit kv, bit good, int prog, int tl, int fail,
                              bit act, bit done);
    vec_t v;
    v.en = en; v.tick = tick; v.kv = kv; v.good = good;
    v.prog = prog; v.tl = tl; v.fail = fail; v.act = act; v.done = done;
    return v;
  endfunction

  vec_t tbl[17];

  initial begin
    tbl[0]  = mk(1, 0, 1, 1, 1, 3, 0, 1, 0);  // correct key
    tbl[1]  = mk(1, 1, 0, 0, 1, 2, 0, 1, 0);  // tick
    tbl[2]  = mk(1, 1, 1, 1, 2, 3, 0, 1, 0);  // key beats tick
    tbl[3]  = mk(1, 0, 1, 0, 2, 3, 1, 1, 0);  // wrong key
    tbl[4]  = mk(1, 0, 0, 0, 0, 3, 1, 1, 0);  // regenerate
    tbl[5]  = mk(1, 1, 0, 0, 0, 2, 1, 1, 0);
    tbl[6]  = mk(1, 1, 0, 0, 0, 1, 1, 1, 0);
    tbl[7]  = mk(1, 1, 0, 0, 0, 0, 2, 1, 0);  // timeout
    tbl[8]  = mk(1, 0, 0, 0, 0, 3, 2, 1, 0);
    tbl[9]  = mk(1, 0, 1, 1, 1, 3, 2, 1, 0);
    tbl[10] = mk(1, 0, 1, 1, 2, 3, 2, 1, 0);
    tbl[11] = mk(1, 0, 1, 1, 3, 3, 2, 1, 0);
    tbl[12] = mk(1, 0, 1, 1, 4, 3, 2, 1, 0);
    tbl[13] = mk(1, 0, 0, 0, 4, 3, 2, 0, 1);  // done pulse
    tbl[14] = mk(1, 0, 1, 0, 4, 3, 2, 0, 0);  // hold ignores key
    tbl[15] = mk(0, 1, 1, 0, 4, 3, 2, 0, 0);  // back to idle
    tbl[16] = mk(0, 1, 1, 0, 4, 3, 2, 0, 0);  // idle ignores key

    repeat (3) @(posedge MCLK);
    @(negedge MCLK);
    check_zero("reset");
    RESET = 1'b0;
    check_model();

    start_game();
    chk("first_tl", int'(time_left), T);
    for (int i = 0; i < 17; i++) begin
      logic [3:0] kval;
      kval = tbl[i].good ? good_key() : 4'd12;
      cyc(tbl[i].en, tbl[i].tick, tbl[i].kv, kval);
      chk($sformatf("vec%0d_progress", i), int'(progress), tbl[i].prog);
      chk($sformatf("vec%0d_time_left", i), int'(time_left), tbl[i].tl);
      chk($sformatf("vec%0d_fail", i), int'(fail_cnt), tbl[i].fail);
      chk($sformatf("vec%0d_active", i), int'(active), int'(tbl[i].act));
      chk($sformatf("vec%0d_done", i), int'(minigame_done), int'(tbl[i].done));
    end

    // Saturation: 20 wrong keys, each followed by the regenerate cycle.
    start_game();
    chk("sat_start_fail", int'(fail_cnt), 0);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 4'(10 + (i % 6)));
      cyc(1'b1, 1'b0, 1'b0, 4'd0);
    end
    chk("sat_fail", int'(fail_cnt), 15);

    // Abort at progress 2, then re-raise.
    cyc(1'b1, 1'b0, 1'b1, good_key());
    cyc(1'b1, 1'b0, 1'b1, good_key());
    chk("abort_pre_prog", int'(progress), 2);
    cyc(1'b0, 1'b0, 1'b0, 4'd0);
    chk("abort_active", int'(active), 0);
    chk("abort_done", int'(minigame_done), 0);
    chk("abort_prog_held", int'(progress), 2);
    cyc(1'b1, 1'b0, 1'b0, 4'd0);
    chk("reraise_fail", int'(fail_cnt), 0);
    cyc(1'b1, 1'b0, 1'b0, 4'd0);
    chk("reraise_active", int'(active), 1);
    chk("reraise_prog", int'(progress), 0);

    // Asynchronous reset mid-game at progress 2.
    cyc(1'b1, 1'b0, 1'b1, good_key());
    cyc(1'b1, 1'b0, 1'b1, good_key());
    chk("rst_pre_prog", int'(progress), 2);
    #1 RESET = 1'b1;
    #1 check_zero("async_rst");
    @(negedge MCLK);
    RESET = 1'b0;
    minigame_enable = 1'b0;
    check_model();
    start_game();

    // Random play against the model.
    for (int i = 0; i < 3000; i++) begin
      bit e, t, k;
      logic [3:0] v;
      e = ($urandom_range(0, 99) >= 4);
      if (m_ph == PHold && $urandom_range(0, 1) == 1) e = 1'b0;
      t = ($urandom_range(0, 99) < 20);
      k = ($urandom_range(0, 99) < 40);
      v = (m_ph == PWait && $urandom_range(0, 99) < 75) ? good_key() : 4'($urandom_range(0, 15));
      cyc(e, t, k, v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
